// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Stall/flush controller for the 5-stage pipeline. Covers the hazards that
//   EX-stage bypassing cannot hide:
//     - load-use: stall PC and IF/ID for one cycle and bubble ID/EX
//     - slow data memory: freeze the whole pipe while the MEM access waits
//     - taken branch resolved in EX: flush IF/ID and ID/EX
//   Outputs are combinational from the registered FSM state and the current
//   inputs. The FSM state, the wait counter and the sticky timeout flag are
//   registered.
//
// Parameters
//   MAX_WAIT : memory-wait cycles before mem_timeout is raised (>= 1)
//   CNT_W    : wait counter width, 2**CNT_W > MAX_WAIT
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   rs1_id, rs2_id             source register addresses of the ID instruction
//   uses_rs1_id, uses_rs2_id   ID instruction actually reads rs1 / rs2
//   rd_ex, MemRead_ex          destination and load flag of the EX instruction
//   branch_taken_ex            EX branch/jump redirects the PC this cycle
//   mem_req_mem, mem_ready     MEM-stage access request / completion
//   pc_write, ifid_write       PC and IF/ID write enables
//   ifid_flush, idex_bubble    IF/ID clear to NOP, ID/EX NOP insert
//   exmem_write                EX/MEM and MEM/WB write enable
//   mem_timeout                sticky: memory wait reached MAX_WAIT
//
// Optional build macro HAZARD_PERF_EN adds stall_cycles[31:0] and
// flush_count[15:0] performance counters (both wrap).

module hazard_stall_unit #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        uses_rs1_id,
  input  logic        uses_rs2_id,
  input  logic [4:0]  rd_ex,
  input  logic        MemRead_ex,
  input  logic        branch_taken_ex,
  input  logic        mem_req_mem,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_write,
  output logic        mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic {ST_RUN, ST_MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_mem_timeout;

  logic             w_freeze;
  logic             w_load_use;
  logic             w_hold;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_freeze   = mem_req_mem & ~mem_ready;
  assign w_load_use = MemRead_ex & (rd_ex != 5'd0) &
                      ((uses_rs1_id & (rd_ex == rs1_id)) |
                       (uses_rs2_id & (rd_ex == rs2_id)));

  // In RUN the freeze is entered on the first not-ready cycle; in MEM_WAIT
  // only mem_ready releases the pipe.
  assign w_hold = (r_state == ST_RUN) ? w_freeze : ~mem_ready;

  assign w_cnt_next = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : (r_wait_cnt + CNT_ONE);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_write = 1'b1;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_write = 1'b0;
    end else if (w_hold) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (branch_taken_ex) begin
      // The branch kills the ID instruction, so any load-use on it is moot.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_freeze) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= CNT_ONE;
            if (CNT_ONE == CNT_MAX) r_mem_timeout <= 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= w_cnt_next;
            if (w_cnt_next == CNT_MAX) r_mem_timeout <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!pc_write)  r_stall_cycles <= r_stall_cycles + 32'd1;
      if (ifid_flush) r_flush_count  <= r_flush_count + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stall rules.
module tb_hazard_stall_unit;

  localparam int MAX_WAIT = 16;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       uses_rs1_id, uses_rs2_id, MemRead_ex, branch_taken_ex;
  logic       mem_req_mem, mem_ready;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  hazard_stall_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .rd_ex(rd_ex), .MemRead_ex(MemRead_ex), .branch_taken_ex(branch_taken_ex),
    .mem_req_mem(mem_req_mem), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_write(exmem_write), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: is the back end waiting on memory, for how long, sticky error.
  bit          m_waiting;
  int          m_wait_len;
  bit          m_timeout;
  int unsigned m_stall;
  logic [15:0] m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write}.
  function automatic logic [4:0] expected_ctrl();
    bit lu;
    if (!rst_n) return 5'b00110;
    if (m_waiting && !mem_ready) return 5'b00000;
    if (!m_waiting && mem_req_mem && !mem_ready) return 5'b00000;
    if (branch_taken_ex) return 5'b11111;
    lu = MemRead_ex && rd_ex != 0 &&
         ((uses_rs1_id && rd_ex == rs1_id) || (uses_rs2_id && rd_ex == rs2_id));
    if (lu) return 5'b00011;
    return 5'b11001;
  endfunction

  function automatic logic [4:0] observed_ctrl();
    return {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write};
  endfunction

  task automatic model_reset();
    m_waiting  = 0;
    m_wait_len = 0;
    m_timeout  = 0;
    m_stall    = 0;
    m_flush    = '0;
  endtask

  // One clock: drive, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                      input logic u2, input logic [4:0] rd, input logic mr,
                      input logic br, input logic req, input logic rdy, input string tag);
    logic [4:0] exp;
    rs1_id = rs1; rs2_id = rs2; uses_rs1_id = u1; uses_rs2_id = u2;
    rd_ex = rd; MemRead_ex = mr; branch_taken_ex = br;
    mem_req_mem = req; mem_ready = rdy;
    @(negedge clk);
    exp = expected_ctrl();
    check({tag, "_ctrl"}, {27'd0, observed_ctrl()}, {27'd0, exp});
    check({tag, "_timeout"}, {31'd0, mem_timeout}, {31'd0, m_timeout});
`ifdef HAZARD_PERF_EN
    check({tag, "_stall_cnt"}, stall_cycles, m_stall);
    check({tag, "_flush_cnt"}, {16'd0, flush_count}, {16'd0, m_flush});
`endif
    @(posedge clk);
    if (rst_n) begin
      if (!exp[4]) m_stall++;
      if (exp[2])  m_flush++;
      if (m_waiting) begin
        if (rdy) begin
          m_waiting = 0; m_wait_len = 0;
        end else begin
          if (m_wait_len < MAX_WAIT) m_wait_len++;
          if (m_wait_len == MAX_WAIT) m_timeout = 1;
        end
      end else if (req && !rdy) begin
        m_waiting = 1; m_wait_len = 1;
        if (m_wait_len == MAX_WAIT) m_timeout = 1;
      end
    end
    #1;
  endtask

  task automatic idle(input string tag);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_id = '0; rs2_id = '0; rd_ex = '0;
    uses_rs1_id = 0; uses_rs2_id = 0; MemRead_ex = 0; branch_taken_ex = 0;
    mem_req_mem = 0; mem_ready = 1;
    model_reset();
    #2;
    check("reset_ctrl", {27'd0, observed_ctrl()}, 32'b00110);
    check("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    idle("normal");

    // Load-use through rs1: one stall cycle, then normal flow.
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, "lu_rs1");
    idle("lu_after");
    // Load-use through rs2.
    step(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, "lu_rs2");
    // x0 destination and unused source never stall.
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, "lu_x0");
    step(5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, "lu_unused");
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, "not_load");

    // Three not-ready cycles, then release.
    for (int i = 0; i < 3; i++)
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "wait3");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, "wait3_release");
    check("wait3_no_timeout", {31'd0, mem_timeout}, 32'd0);

    // Release cycle carrying a load-use.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "wait_lu");
    step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, "wait_lu_release");

    // Branch beats load-use.
    step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, "branch_over_lu");

    // Long wait: timeout after MAX_WAIT cycles, sticky after ready.
    for (int i = 0; i < MAX_WAIT + 2; i++)
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "long_wait");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, "long_release");
    idle("timeout_sticky");
    check("timeout_held", {31'd0, mem_timeout}, 32'd1);

    // Reset in the middle of a memory wait.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "pre_reset_wait");
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "pre_reset_wait");
    rst_n = 1'b0;
    #1;
    check("midwait_reset_ctrl", {27'd0, observed_ctrl()}, 32'b00110);
    check("midwait_reset_timeout", {31'd0, mem_timeout}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Back in RUN: no ready needed while no memory request is pending.
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "after_reset");

    // Random traffic with small register indices so hazards actually occur.
    for (int i = 0; i < 400; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 9) < 7), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
